// File: rtl/pmem_responder_if.sv
// rtl/pmem_responder_if.sv - pmem line request/response bus between the L2 datapath and the responder
//
// Signals:
//   pmem_read     L2 -> responder  line read request, held until pmem_resp
//   pmem_write    L2 -> responder  line write request, held until pmem_resp
//   pmem_address  L2 -> responder  16-bit line address, bits [3:0] ignored
//   pmem_wdata    L2 -> responder  128-bit write line
//   pmem_resp     responder -> L2  one-cycle completion pulse
//   pmem_rdata    responder -> L2  128-bit read line
//   pmem_err      responder -> L2  sticky protocol-error flag
interface pmem_responder_if;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic         pmem_resp;
   logic [127:0] pmem_rdata;
   logic         pmem_err;

   modport master (
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_resp, pmem_rdata, pmem_err
   );

   modport slave (
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_resp, pmem_rdata, pmem_err
   );
endinterface

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency 128-bit line memory model answering L2 pmem requests
//
// Ports:
//   clk       sole clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       pmem_responder_if.slave (read/write request, address, wdata, resp, rdata, err)
//   rd_count  completed reads  (constant 0 unless PMEM_STATS_EN is defined)
//   wr_count  completed writes (constant 0 unless PMEM_STATS_EN is defined)
//
// Optional feature macro: PMEM_STATS_EN enables saturating rd_count/wr_count counters.
module pmem_responder #(
   parameter int unsigned LATENCY  = 4,
   parameter int unsigned IDX_BITS = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   pmem_responder_if.slave   bus,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
);

   localparam int unsigned DEPTH       = 1 << IDX_BITS;
   localparam logic [7:0]  LAT_LOAD    = 8'(LATENCY - 1);
   localparam bit          DIRECT_RESP = (LATENCY == 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          lat_cnt_q, lat_cnt_d;
   logic [IDX_BITS-1:0] idx_q, idx_d;
   logic                op_write_q, op_write_d;
   logic [127:0]        wdata_q, wdata_d;
   logic [127:0]        rdata_q, rdata_d;
   logic                err_q, err_d;

   // Line storage; deliberately outside the reset so contents survive reset_n.
   logic [127:0]        mem_q [DEPTH] = '{default: '0};

   logic [IDX_BITS-1:0] addr_idx;
   logic                unused_addr;

   assign addr_idx    = bus.pmem_address[IDX_BITS+3:4];
   assign unused_addr = ^{bus.pmem_address[15:IDX_BITS+4], bus.pmem_address[3:0]};

   always_comb begin
      state_d    = state_q;
      lat_cnt_d  = lat_cnt_q;
      idx_d      = idx_q;
      op_write_d = op_write_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;

      unique case (state_q)
         IDLE: begin
            if (bus.pmem_read || bus.pmem_write) begin
               idx_d      = addr_idx;
               // Write wins when both are requested; the read is dropped.
               op_write_d = bus.pmem_write;
               wdata_d    = bus.pmem_wdata;
               lat_cnt_d  = LAT_LOAD;
               if (bus.pmem_read && bus.pmem_write) begin
                  err_d = 1'b1;
               end
               if (DIRECT_RESP) begin
                  state_d = RESP;
                  // rdata must already be valid during the RESP cycle.
                  if (!bus.pmem_write) begin
                     rdata_d = mem_q[addr_idx];
                  end
               end else begin
                  state_d = BUSY;
               end
            end
         end

         BUSY: begin
            // Requester dropped its request before completion: finish anyway, flag it.
            if ((op_write_q && !bus.pmem_write) || (!op_write_q && !bus.pmem_read)) begin
               err_d = 1'b1;
            end
            if (lat_cnt_q == 8'd0) begin
               state_d = RESP;
               if (!op_write_q) begin
                  rdata_d = mem_q[idx_q];
               end
            end else begin
               lat_cnt_d = lat_cnt_q - 8'd1;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         lat_cnt_q  <= 8'd0;
         idx_q      <= '0;
         op_write_q <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         lat_cnt_q  <= lat_cnt_d;
         idx_q      <= idx_d;
         op_write_q <= op_write_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

   // Commit at the edge that ends RESP; reset_n gate keeps an aborted write out.
   always_ff @(posedge clk) begin
      if (reset_n && (state_q == RESP) && op_write_q) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign bus.pmem_resp  = (state_q == RESP);
   assign bus.pmem_rdata = rdata_q;
   assign bus.pmem_err   = err_q;

`ifdef PMEM_STATS_EN
   logic [15:0] rd_count_q, rd_count_d;
   logic [15:0] wr_count_q, wr_count_d;

   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (state_q == RESP) begin
         if (op_write_q) begin
            if (wr_count_q != 16'hFFFF) begin
               wr_count_d = wr_count_q + 16'd1;
            end
         end else begin
            if (rd_count_q != 16'hFFFF) begin
               rd_count_d = rd_count_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_count_q <= 16'd0;
         wr_count_q <= 16'd0;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`else
   assign rd_count = 16'd0;
   assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - self-checking bench for pmem_responder (LATENCY=4 and LATENCY=1 instances)
module tb_pmem_responder;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   logic [15:0] rd_a, wr_a, rd_b, wr_b;

   always #5 clk = ~clk;

   pmem_responder_if if_a ();
   pmem_responder_if if_b ();

   pmem_responder #(.LATENCY(4), .IDX_BITS(5)) u_dut (
      .clk      (clk),
      .reset_n  (rst_a),
      .bus      (if_a),
      .rd_count (rd_a),
      .wr_count (wr_a)
   );

   pmem_responder #(.LATENCY(1), .IDX_BITS(5)) u_dut1 (
      .clk      (clk),
      .reset_n  (rst_b),
      .bus      (if_b),
      .rd_count (rd_b),
      .wr_count (wr_b)
   );

`ifdef PMEM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: plain array of lines, index = (address / 16) mod 32.
   logic [127:0] model_mem [32];
   logic [127:0] model_rdata;
   int           model_rd;
   int           model_wr;

   typedef struct {
      bit           rd;
      bit           wr;
      logic [15:0]  addr;
      logic [127:0] wdata;
      logic [127:0] exp_rdata;
      bit           exp_err;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int midx(input logic [15:0] addr);
      return (int'(addr) / 16) % 32;
   endfunction

   task automatic do_txn(input bit rd, input bit wr, input logic [15:0] addr, input logic [127:0] wd,
                         input bit perturb, input bit drop,
                         output logic [127:0] rdata, output logic err, output int lat);
      @(negedge clk);
      if_a.pmem_read    = rd;
      if_a.pmem_write   = wr;
      if_a.pmem_address = addr;
      if_a.pmem_wdata   = wd;
      @(posedge clk);
      lat = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (i == 0 && perturb) begin
            if_a.pmem_address = 16'h0500;
            if_a.pmem_wdata   = ~wd;
         end
         if (i == 0 && drop) begin
            if_a.pmem_read  = 1'b0;
            if_a.pmem_write = 1'b0;
         end
         if (if_a.pmem_resp) break;
         @(posedge clk);
         lat++;
      end
      rdata = if_a.pmem_rdata;
      err   = if_a.pmem_err;
      if (!if_a.pmem_resp) $display("FAIL resp_timeout: got no pmem_resp expected one within 300 cycles");
      if_a.pmem_read  = 1'b0;
      if_a.pmem_write = 1'b0;
      @(posedge clk);
   endtask

   // Drives one transaction, checks latency/rdata/err against the model, then updates the model.
   task automatic run_txn(input string name, input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [127:0] wd, input bit perturb, input bit drop, input bit exp_err);
      logic [127:0] got;
      logic         err;
      int           lat;
      logic [127:0] exp_rd;
      exp_rd = (rd && !wr) ? model_mem[midx(addr)] : model_rdata;
      do_txn(rd, wr, addr, wd, perturb, drop, got, err, lat);
      chk({name, "_lat"}, 128'(lat), 128'd4);
      chk({name, "_rdata"}, got, exp_rd);
      chk({name, "_err"}, 128'(err), 128'(exp_err));
      if (wr) begin
         model_mem[midx(addr)] = wd;
         model_wr++;
      end else begin
         model_rdata = exp_rd;
         model_rd++;
      end
   endtask

   task automatic pulse_reset_a;
      @(negedge clk);
      rst_a = 1'b0;
      @(negedge clk);
      rst_a = 1'b1;
      model_rdata = '0;
      model_rd = 0;
      model_wr = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      logic [15:0]  a;
      logic [127:0] d;
      bit           op;

      for (int i = 0; i < 32; i++) model_mem[i] = '0;
      model_rdata = '0;
      model_rd = 0;
      model_wr = 0;
      if_a.pmem_read = 1'b0; if_a.pmem_write = 1'b0; if_a.pmem_address = '0; if_a.pmem_wdata = '0;
      if_b.pmem_read = 1'b0; if_b.pmem_write = 1'b0; if_b.pmem_address = '0; if_b.pmem_wdata = '0;

      vecs[0] = '{0, 1, 16'h0240, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0, 128'h0, 0};
      vecs[1] = '{1, 0, 16'h0240, 128'h0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0, 0};
      vecs[2] = '{1, 0, 16'h0440, 128'h0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0, 0};
      vecs[3] = '{1, 0, 16'h0300, 128'h0, 128'h0, 0};
      vecs[4] = '{0, 1, 16'h0200, 128'hAAAA_0200, 128'h0, 0};
      vecs[5] = '{0, 1, 16'h0500, 128'hBBBB_0500, 128'h0, 0};
      vecs[6] = '{1, 0, 16'h0300, 128'h0, 128'hBBBB_0500, 0};

      // Asynchronous reset: outputs clear before any clock edge.
      #2;
      rst_a = 1'b0;
      rst_b = 1'b0;
      #1;
      chk("rst_resp", 128'(if_a.pmem_resp), 128'd0);
      chk("rst_rdata", if_a.pmem_rdata, 128'd0);
      chk("rst_err", 128'(if_a.pmem_err), 128'd0);
      chk("rst_rd_count", 128'(rd_a), 128'd0);
      chk("rst_wr_count", 128'(wr_a), 128'd0);
      chk("rst_b_resp", 128'(if_b.pmem_resp), 128'd0);
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      rst_b = 1'b1;

      // Table-driven vectors.
      for (int v = 0; v < 7; v++) begin
         logic [127:0] got;
         logic         err;
         int           lat;
         do_txn(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, 1'b0, 1'b0, got, err, lat);
         chk($sformatf("vec%0d_lat", v), 128'(lat), 128'd4);
         chk($sformatf("vec%0d_rdata", v), got, vecs[v].exp_rdata);
         chk($sformatf("vec%0d_err", v), 128'(err), 128'(vecs[v].exp_err));
         if (vecs[v].wr) begin
            model_mem[midx(vecs[v].addr)] = vecs[v].wdata;
            model_wr++;
         end else begin
            model_rdata = vecs[v].exp_rdata;
            model_rd++;
         end
      end

      // Address/data change during BUSY does not affect the read in flight.
      run_txn("perturb", 1'b1, 1'b0, 16'h0200, 128'h0, 1'b1, 1'b0, 1'b0);
      chk("perturb_value", model_rdata, 128'hAAAA_0200);

      // Read and write together: write wins, error is flagged and sticks.
      run_txn("both", 1'b1, 1'b1, 16'h0100, 128'h1, 1'b0, 1'b0, 1'b1);
      run_txn("both_rd", 1'b1, 1'b0, 16'h0100, 128'h0, 1'b0, 1'b0, 1'b1);
      chk("both_rd_value", model_rdata, 128'h1);
      chk("cnt_rd_mid", 128'(rd_a), STATS ? 128'(model_rd) : 128'd0);
      chk("cnt_wr_mid", 128'(wr_a), STATS ? 128'(model_wr) : 128'd0);

      // Reset two cycles into a write to 0x0300: aborted, nothing written.
      @(negedge clk);
      if_a.pmem_write   = 1'b1;
      if_a.pmem_address = 16'h0300;
      if_a.pmem_wdata   = {4{32'hFFFF_FFFF}};
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_a = 1'b0;
      #1;
      chk("abort_resp", 128'(if_a.pmem_resp), 128'd0);
      chk("abort_rdata", if_a.pmem_rdata, 128'd0);
      chk("abort_err", 128'(if_a.pmem_err), 128'd0);
      chk("abort_rd_count", 128'(rd_a), 128'd0);
      @(negedge clk);
      if_a.pmem_write = 1'b0;
      @(negedge clk);
      rst_a = 1'b1;
      model_rdata = '0;
      model_rd = 0;
      model_wr = 0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (if_a.pmem_resp) seen++;
      end
      chk("abort_no_resp", 128'(seen), 128'd0);
      run_txn("abort_rd", 1'b1, 1'b0, 16'h0300, 128'h0, 1'b0, 1'b0, 1'b0);
      chk("abort_rd_value", model_rdata, 128'h1);

      // Request dropped early: still completes, error set.
      run_txn("drop", 1'b1, 1'b0, 16'h0240, 128'h0, 1'b0, 1'b1, 1'b1);
      chk("drop_value", model_rdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0);

      // Randomized traffic against the model.
      pulse_reset_a();
      for (int i = 0; i < 40; i++) begin
         op = 1'($urandom_range(0, 1));
         a  = 16'($urandom);
         d  = {$urandom, $urandom, $urandom, $urandom};
         run_txn($sformatf("rnd%0d", i), !op, op, a, d, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      chk("cnt_rd_end", 128'(rd_a), STATS ? 128'(model_rd) : 128'd0);
      chk("cnt_wr_end", 128'(wr_a), STATS ? 128'(model_wr) : 128'd0);

      // LATENCY=1: reads held continuously complete every second cycle.
      @(negedge clk);
      if_b.pmem_read    = 1'b1;
      if_b.pmem_address = 16'h0010;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("b2b_resp%0d", i), 128'(if_b.pmem_resp), (i % 2 == 0) ? 128'd1 : 128'd0);
      end
      if_b.pmem_read = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("b2b_rd_count", 128'(rd_b), STATS ? 128'd3 : 128'd0);
      chk("b2b_err", 128'(if_b.pmem_err), 128'd0);
      chk("b2b_rdata", if_b.pmem_rdata, 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request acceptance to pmem_resp; legal range 1..255.
REQ-002 Parameter IDX_BITS, default 5, line-index width; storage holds 2**IDX_BITS 128-bit lines indexed by pmem_address[IDX_BITS+3:4].
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 pmem_read  input  1  line read request from the L2 cache datapath, held high until pmem_resp.
REQ-006 pmem_write  input  1  line write request, held high until pmem_resp.
REQ-007 pmem_address  input  16 (lc3b_word)  line address; bits [3:0] ignored.
REQ-008 pmem_wdata  input  128 (lc3b_cacheline)  write line.
REQ-009 pmem_resp  output  1  one-cycle completion pulse.
REQ-010 pmem_rdata  output  128 (lc3b_cacheline)  read line.
REQ-011 pmem_err  output  1  sticky protocol-error flag.
REQ-012 rd_count, wr_count  output  16 each  completed-transaction counters (see Configuration).

Function
REQ-013 FSM states IDLE, BUSY, RESP; IDLE after reset.
REQ-014 IDLE: on an edge with pmem_read or pmem_write high, latch address index, operation and pmem_wdata; load latency counter with LATENCY-1; go to BUSY if LATENCY>1, else RESP.
REQ-015 BUSY: decrement counter each cycle; at counter 0 go to RESP; request inputs ignored while BUSY.
REQ-016 RESP: pmem_resp high for exactly this one cycle, then IDLE unconditionally.
REQ-017 Latency: request sampled at edge E; pmem_resp high in the cycle starting at edge E+LATENCY.
REQ-018 Read: pmem_rdata = line at latched index, valid in RESP cycle and held until the next read completes.
REQ-019 Write: latched wdata written to latched index at the edge ending RESP; pmem_rdata unchanged.
REQ-020 Address, data or request changes after acceptance do not affect the transaction in flight.
REQ-021 pmem_read and pmem_write both high at acceptance: write performed, read dropped, pmem_err set.
REQ-022 A request deasserted before pmem_resp is still completed; pmem_err set.
REQ-023 Address bits above IDX_BITS+3 alias; no error.
REQ-024 Back-to-back: a request still high in the cycle after RESP is accepted as a new transaction at the next edge.
REQ-025 Storage initialised to all zeros at elaboration.

Reset
REQ-026 reset_n low forces IDLE, pmem_resp 0, pmem_rdata 0, pmem_err 0, counters 0, latency counter 0, immediately and independent of clk.
REQ-027 Reset mid-transaction aborts it: no resp issued, no storage write; storage contents otherwise preserved.
REQ-028 First acceptance possible at the first rising edge after reset_n deasserts.

Configuration
REQ-029 Macro PMEM_STATS_EN: when defined, rd_count and wr_count increment by 1 at the edge ending each RESP of the matching operation, saturating at 16'hFFFF.
REQ-030 Without PMEM_STATS_EN, rd_count and wr_count are constant 0 and no counter flops exist.

Verification
REQ-031 LATENCY=4: write 0x0240 with 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0, then read 0x0240 -> each pmem_resp exactly 4 cycles after acceptance, read returns written line.
REQ-032 IDX_BITS=5: write line A to 0x0240, read 0x0440 (same index) -> returns A, pmem_err 0.
REQ-033 pmem_read and pmem_write high together at 0x0100 with wdata 128'h1 -> write committed, pmem_err 1, subsequent read of 0x0100 returns 128'h1.
REQ-034 reset_n pulsed low 2 cycles into a write to 0x0300 -> no pmem_resp, outputs 0, later read of 0x0300 returns prior contents.
REQ-035 LATENCY=1, three back-to-back reads held continuously -> pmem_resp every second cycle; with PMEM_STATS_EN rd_count=3, without it 0.
REQ-036 Change pmem_address from 0x0200 to 0x0500 during BUSY of a read -> data returned from 0x0200.
